mpu_byte_memory: RTL and testbench

MPU_BYTE_MEMORY -- requirements
Module: mpu_byte_memory

---
 rtl/mpu_mem_pkg.sv | 16 +
 rtl/mpu_mem_clear.sv | 46 ++++
 rtl/mpu_byte_memory.sv | 110 +++++++++++
 tb/tb_mpu_byte_memory.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mpu_mem_pkg.sv
// mpu_mem_pkg
//   Shared definitions for the byte-addressable MPU memory slice:
//   control state encoding and the default geometry parameters.
//   No ports (package).
package mpu_mem_pkg;

   // Control FSM encoding, kept as plain constants for legacy tools.
   localparam logic [0:0] MEM_CLEAR = 1'b0;
   localparam logic [0:0] MEM_READY = 1'b1;

   // Default geometry: 64 KiB, 6-byte read port, 4-byte write port.
   localparam int DEF_ADDR_W   = 16;
   localparam int DEF_RD_BYTES = 6;
   localparam int DEF_WR_BYTES = 4;

endpackage

// File: rtl/mpu_mem_clear.sv
// mpu_mem_clear
//   Zero-fill sweep counter. Walks ptr from 0 to the last WR_BYTES-aligned
//   word, one word per cycle, and drops busy once the last word is done.
// Ports:
//   sys_clk   in   clock, rising edge
//   sys_rst_n in   synchronous active-low reset; starts a sweep from 0
//   start     in   restart the sweep from 0 (takes priority over advancing)
//   busy      out  sweep in progress; ptr is the word being zeroed
//   ptr       out  byte address of the word being zeroed this cycle
module mpu_mem_clear
   import mpu_mem_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int WR_BYTES = DEF_WR_BYTES
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              start,
   output logic              busy,
   output logic [ADDR_W-1:0] ptr
);

   localparam int              DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - WR_BYTES);
   localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(WR_BYTES);

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values and the order of statements does not matter.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         busy <= 1'b1;
         ptr  <= '0;
      end else if (start) begin
         busy <= 1'b1;
         ptr  <= '0;
      end else if (busy) begin
         // The last word is zeroed in this cycle; ready follows on the next.
         if (ptr == LAST_PTR) begin
            busy <= 1'b0;
         end else begin
            ptr <= ptr + STEP;
         end
      end
   end

endmodule

// File: rtl/mpu_byte_memory.sv
// mpu_byte_memory
//   Byte-addressable memory with an unaligned RD_BYTES-wide read port
//   (1-cycle registered latency, read-first) and an unaligned WR_BYTES-wide
//   byte-enabled write port. All addresses wrap modulo 2^ADDR_W. After reset
//   or a clr pulse the whole array is zero-filled by a sweep; accesses are
//   ignored while the sweep runs.
// Ports:
//   sys_clk   in   clock, rising edge
//   sys_rst_n in   synchronous active-low reset
//   clr       in   restart the zero-fill sweep
//   ready     out  no sweep in progress, accesses accepted
//   r_req     in   read request
//   r_addr    in   byte address of read byte 0
//   r_data    out  little-endian read data, byte k from r_addr+k
//   r_valid   out  r_data belongs to the request of the previous cycle
//   we        in   write strobe
//   w_addr    in   byte address of write byte 0
//   w_data    in   little-endian write data
//   w_be      in   per-byte write enable, bit k gates byte w_addr+k
module mpu_byte_memory
   import mpu_mem_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int RD_BYTES = DEF_RD_BYTES,
   parameter int WR_BYTES = DEF_WR_BYTES
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  clr,
   output logic                  ready,
   input  logic                  r_req,
   input  logic [ADDR_W-1:0]     r_addr,
   output logic [8*RD_BYTES-1:0] r_data,
   output logic                  r_valid,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     w_addr,
   input  logic [8*WR_BYTES-1:0] w_data,
   input  logic [WR_BYTES-1:0]   w_be
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [7:0]            mem [DEPTH];
   logic                  clr_busy;
   logic [ADDR_W-1:0]     clr_ptr;
   logic [0:0]            state;
   logic                  rd_accept;
   logic                  wr_accept;
   logic [8*RD_BYTES-1:0] rd_word;

   mpu_mem_clear #(
      .ADDR_W   (ADDR_W),
      .WR_BYTES (WR_BYTES)
   ) u_clear (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .start     (clr),
      .busy      (clr_busy),
      .ptr       (clr_ptr)
   );

   // The sweep counter's busy flag is the single state bit of the FSM.
   assign state     = clr_busy ? MEM_CLEAR : MEM_READY;
   assign ready     = (state == MEM_READY);
   assign rd_accept = ready & r_req;
   assign wr_accept = ready & we;

   // Byte selects for the read port; ADDR_W-bit addition provides the wrap.
   // NOTE: the default assignment before the loop keeps this block purely
   // combinational, so no latch is inferred.
   always_comb begin
      rd_word = '0;
      for (int k = 0; k < RD_BYTES; k++) begin
         rd_word[8*k +: 8] = mem[r_addr + ADDR_W'(k)];
      end
   end

   // NOTE: the byte array has no reset branch; it is zeroed by the sweep so
   // it can map onto plain RAM. Writes are only held off while reset is low.
   always_ff @(posedge sys_clk) begin
      if (sys_rst_n) begin
         if (state == MEM_CLEAR) begin
            for (int k = 0; k < WR_BYTES; k++) begin
               mem[clr_ptr + ADDR_W'(k)] <= 8'h00;
            end
         end else if (wr_accept) begin
            for (int k = 0; k < WR_BYTES; k++) begin
               if (w_be[k]) begin
                  mem[w_addr + ADDR_W'(k)] <= w_data[8*k +: 8];
               end
            end
         end
      end
   end

   // Output register samples rd_word from the pre-write array (read-first)
   // and holds its value when no read is accepted.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         r_valid <= rd_accept;
         if (rd_accept) begin
            r_data <= rd_word;
         end
      end
   end

endmodule

// File: tb/tb_mpu_byte_memory.sv
// tb_mpu_byte_memory
//   Self-checking bench for mpu_byte_memory (ADDR_W=8, RD_BYTES=6,
//   WR_BYTES=4). A byte-array reference model tracks memory contents and the
//   expected read register; directed steps cover sweep timing, unaligned and
//   wrapping accesses, byte enables, read-first and clr/reset behaviour,
//   followed by a randomized phase.
module tb_mpu_byte_memory;

   localparam int ADDR_W   = 8;
   localparam int RD_BYTES = 6;
   localparam int WR_BYTES = 4;
   localparam int DEPTH    = 256;
   localparam int SWEEP    = DEPTH / WR_BYTES;

   logic        sys_clk   = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        clr       = 1'b0;
   logic        ready;
   logic        r_req     = 1'b0;
   logic [7:0]  r_addr    = '0;
   logic [47:0] r_data;
   logic        r_valid;
   logic        we        = 1'b0;
   logic [7:0]  w_addr    = '0;
   logic [31:0] w_data    = '0;
   logic [3:0]  w_be      = '0;

   int checks = 0;
   int errors = 0;

   logic [7:0]  ref_mem [DEPTH];
   logic [47:0] exp_rdata = '0;

   mpu_byte_memory #(
      .ADDR_W   (ADDR_W),
      .RD_BYTES (RD_BYTES),
      .WR_BYTES (WR_BYTES)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .clr       (clr),
      .ready     (ready),
      .r_req     (r_req),
      .r_addr    (r_addr),
      .r_data    (r_data),
      .r_valid   (r_valid),
      .we        (we),
      .w_addr    (w_addr),
      .w_data    (w_data),
      .w_be      (w_be)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [47:0] model_read(input int addr);
      logic [47:0] v;
      for (int k = 0; k < RD_BYTES; k++) v[8*k +: 8] = ref_mem[(addr + k) % DEPTH];
      return v;
   endfunction

   task automatic model_write(input int addr, input logic [31:0] data, input logic [3:0] be);
      for (int k = 0; k < WR_BYTES; k++)
         if (be[k]) ref_mem[(addr + k) % DEPTH] = data[8*k +: 8];
   endtask

   task automatic model_zero();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
   endtask

   // One READY-mode cycle: drive, clock, update the model, compare.
   task automatic op(input string tag, input logic rq, input logic [7:0] ra,
                     input logic wen, input logic [7:0] wa, input logic [31:0] wd,
                     input logic [3:0] wb);
      logic [47:0] pre;
      pre    = model_read(int'(ra));
      r_req  = rq;  r_addr = ra;
      we     = wen; w_addr = wa; w_data = wd; w_be = wb;
      @(posedge sys_clk); #1;
      r_req = 1'b0; we = 1'b0;
      if (rq) exp_rdata = pre;
      if (wen) model_write(int'(wa), wd, wb);
      check({tag, " valid"}, 64'(r_valid), 64'(rq));
      check({tag, " data"}, 64'(r_data), 64'(exp_rdata));
   endtask

   // Count cycles until ready while hammering the ports, which must be ignored.
   task automatic wait_sweep(input string tag);
      int n;
      n = 0;
      while (!ready && n < 4 * SWEEP) begin
         r_req  = 1'($urandom);
         r_addr = 8'($urandom);
         we     = 1'b1;
         w_addr = 8'($urandom);
         w_data = $urandom;
         w_be   = 4'hF;
         @(posedge sys_clk); #1;
         n++;
         check({tag, " busy valid"}, 64'(r_valid), 64'(0));
         check({tag, " busy hold"}, 64'(r_data), 64'(exp_rdata));
      end
      r_req = 1'b0; we = 1'b0;
      check({tag, " sweep cycles"}, 64'(n), 64'(SWEEP));
      model_zero();
   endtask

   initial begin
      // Reset state.
      repeat (2) @(posedge sys_clk);
      #1;
      check("rst ready", 64'(ready), 64'(0));
      check("rst valid", 64'(r_valid), 64'(0));
      check("rst data", 64'(r_data), 64'(0));

      // Release: exactly SWEEP cycles of not-ready, then all zeros.
      sys_rst_n = 1'b1;
      exp_rdata = '0;
      wait_sweep("post reset");
      op("read 0 zero", 1'b1, 8'h00, 1'b0, 8'h00, 32'h0, 4'h0);
      check("read 0 const", 64'(r_data), 64'(0));

      // Unaligned write then unaligned read.
      op("uw write", 1'b0, 8'h00, 1'b1, 8'h03, 32'hDDCCBBAA, 4'hF);
      op("uw read", 1'b1, 8'h02, 1'b0, 8'h00, 32'h0, 4'h0);
      check("uw const", 64'(r_data), 64'(48'h0000DDCCBBAA00));

      // Byte enables.
      op("be write", 1'b0, 8'h00, 1'b1, 8'h10, 32'h11223344, 4'b0101);
      op("be read", 1'b1, 8'h10, 1'b0, 8'h00, 32'h0, 4'h0);
      check("be const", 64'(r_data), 64'(48'h000000220044));

      // Empty byte enable changes nothing.
      op("be0 write", 1'b0, 8'h00, 1'b1, 8'h10, 32'hFFFFFFFF, 4'b0000);
      op("be0 read", 1'b1, 8'h10, 1'b0, 8'h00, 32'h0, 4'h0);

      // Wrap-around write and read.
      op("wrap write", 1'b0, 8'h00, 1'b1, 8'hFE, 32'h44332211, 4'hF);
      op("wrap read", 1'b1, 8'hFD, 1'b0, 8'h00, 32'h0, 4'h0);
      check("wrap const", 64'(r_data), 64'(48'h004433221100));

      // Read-first collision.
      op("rf seed", 1'b0, 8'h00, 1'b1, 8'h20, 32'h00000055, 4'b0001);
      op("rf collide", 1'b1, 8'h20, 1'b1, 8'h20, 32'h000000AA, 4'b0001);
      check("rf old byte", 64'(r_data[7:0]), 64'(8'h55));
      op("rf after", 1'b1, 8'h20, 1'b0, 8'h00, 32'h0, 4'h0);
      check("rf new byte", 64'(r_data[7:0]), 64'(8'hAA));

      // Hold when no read is accepted.
      op("hold", 1'b0, 8'h40, 1'b0, 8'h00, 32'h0, 4'h0);

      // Randomized READY traffic.
      for (int i = 0; i < 60; i++) begin
         op("rand", 1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
            $urandom, 4'($urandom));
         check("rand ready", 64'(ready), 64'(1));
      end

      // Read in the cycle clr is sampled completes in the first CLEAR cycle.
      exp_rdata = model_read(3);
      r_req = 1'b1; r_addr = 8'h03; clr = 1'b1;
      @(posedge sys_clk); #1;
      r_req = 1'b0; clr = 1'b0;
      check("clr last read valid", 64'(r_valid), 64'(1));
      check("clr last read data", 64'(r_data), 64'(exp_rdata));
      check("clr ready low", 64'(ready), 64'(0));

      // Partial sweep with ignored accesses, then clr again mid-sweep.
      for (int i = 0; i < 20; i++) begin
         r_req = 1'b1; r_addr = 8'($urandom);
         we = 1'b1; w_addr = 8'($urandom); w_data = $urandom; w_be = 4'hF;
         @(posedge sys_clk); #1;
         check("partial valid", 64'(r_valid), 64'(0));
         check("partial ready", 64'(ready), 64'(0));
      end
      r_req = 1'b0; we = 1'b0;
      clr = 1'b1;
      @(posedge sys_clk); #1;
      clr = 1'b0;
      wait_sweep("mid clr");

      // Whole memory must read zero (final read wraps past the top).
      for (int a = 0; a < DEPTH; a += RD_BYTES) begin
         op("zero scan", 1'b1, 8'(a), 1'b0, 8'h00, 32'h0, 4'h0);
      end

      // Reset during a read aborts it and restarts the sweep.
      op("pre rst write", 1'b0, 8'h00, 1'b1, 8'h80, 32'hCAFEF00D, 4'hF);
      r_req = 1'b1; r_addr = 8'h80; sys_rst_n = 1'b0;
      @(posedge sys_clk); #1;
      r_req = 1'b0;
      check("mid rst valid", 64'(r_valid), 64'(0));
      check("mid rst data", 64'(r_data), 64'(0));
      check("mid rst ready", 64'(ready), 64'(0));
      sys_rst_n = 1'b1;
      exp_rdata = '0;
      wait_sweep("re-reset");
      op("re-reset read", 1'b1, 8'h80, 1'b0, 8'h00, 32'h0, 4'h0);
      check("re-reset const", 64'(r_data), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
